// File: rtl/mem_stage.sv
// Memory stage: EX->MEM pipeline register, load-data alignment/extension and
// a small FSM that tracks an outstanding or stalled load from data memory.
module mem_stage (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  stall,
  input  logic [73:0] ex_to_mem_bus,
  input  logic [65:0] hl_ex_to_mem,
  input  logic [31:0] data_sram_rdata,
  input  logic        data_sram_rvalid,
  output logic [69:0] mem_to_wb_bus,
  output logic [65:0] hl_mem_to_wb,
  output logic [37:0] mem_to_id_bus,
  output logic [65:0] mem_to_id_hl,
  output logic        stallreq_mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [73:0] bus_q, bus_d;
  logic [65:0] hl_q, hl_d;
  logic [31:0] hold_q, hold_d;

  logic        bubble_s;
  logic [31:0] pc_s, ex_result_s, src_s, ld_val_s, wdata_s;
  logic        ld_en_s, rf_we_s;
  logic [2:0]  ld_type_s;
  logic [4:0]  waddr_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        unused_stall_s;

  assign unused_stall_s = ^{stall[5], stall[2:0]};
  assign bubble_s       = stall[3] & ~stall[4];
  assign {pc_s, ld_en_s, ld_type_s, rf_we_s, waddr_s, ex_result_s} = bus_q;

  // EX->MEM register next state: bubble beats capture beats hold
  always_comb begin
    bus_d = bus_q;
    hl_d  = hl_q;
    if (bubble_s) begin
      bus_d = 74'd0;
      hl_d  = 66'd0;
    end else if (!stall[3]) begin
      bus_d = ex_to_mem_bus;
      hl_d  = hl_ex_to_mem;
    end else begin
      bus_d = bus_q;
      hl_d  = hl_q;
    end
  end

  // Load FSM next state; hold_data captures rdata on every entry into HOLD
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_IDLE: begin
        if (ld_en_s && !data_sram_rvalid) begin
          state_d = S_WAIT;
        end else if (ld_en_s && data_sram_rvalid && stall[4]) begin
          state_d = S_HOLD;
          hold_d  = data_sram_rdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (bubble_s) begin
          state_d = S_IDLE;
        end else if (data_sram_rvalid && stall[4]) begin
          state_d = S_HOLD;
          hold_d  = data_sram_rdata;
        end else if (data_sram_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (bubble_s || !stall[4]) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Stage state registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_q   <= 74'd0;
      hl_q    <= 66'd0;
      hold_q  <= 32'd0;
      state_q <= S_IDLE;
    end else begin
      bus_q   <= bus_d;
      hl_q    <= hl_d;
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  // Little-endian lane selection and sign/zero extension of the load word
  always_comb begin
    src_s = (state_q == S_HOLD) ? hold_q : data_sram_rdata;
    case (ex_result_s[1:0])
      2'b00:   byte_s = src_s[7:0];
      2'b01:   byte_s = src_s[15:8];
      2'b10:   byte_s = src_s[23:16];
      2'b11:   byte_s = src_s[31:24];
      default: byte_s = src_s[7:0];
    endcase
    if (ex_result_s[1]) begin
      half_s = src_s[31:16];
    end else begin
      half_s = src_s[15:0];
    end
    case (ld_type_s)
      3'b000:  ld_val_s = {{24{byte_s[7]}}, byte_s};
      3'b001:  ld_val_s = {24'd0, byte_s};
      3'b010:  ld_val_s = {{16{half_s[15]}}, half_s};
      3'b011:  ld_val_s = {16'd0, half_s};
      default: ld_val_s = src_s;
    endcase
  end

  assign wdata_s       = ld_en_s ? ld_val_s : ex_result_s;
  assign stallreq_mem  = ld_en_s & ~data_sram_rvalid & (state_q != S_HOLD);
  assign mem_to_wb_bus = {pc_s, rf_we_s, waddr_s, wdata_s};
  assign mem_to_id_bus = {rf_we_s & ~stallreq_mem, waddr_s, wdata_s};
  assign hl_mem_to_wb  = hl_q;
  assign mem_to_id_hl  = hl_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked every cycle against a
// behavioural model of the stage (register, load mode, held word).
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic [73:0] exb;
  logic [65:0] hlin;
  logic [31:0] rdata;
  logic        rvalid;
  logic [69:0] mem_to_wb_bus;
  logic [65:0] hl_mem_to_wb;
  logic [37:0] mem_to_id_bus;
  logic [65:0] mem_to_id_hl;
  logic        stallreq_mem;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: 0 = idle, 1 = waiting for data, 2 = holding latched word
  logic [73:0] m_bus;
  logic [65:0] m_hl;
  logic [31:0] m_hold;
  int          m_mode;

  mem_stage dut (
    .clk(clk), .resetn(resetn), .stall(stall),
    .ex_to_mem_bus(exb), .hl_ex_to_mem(hlin),
    .data_sram_rdata(rdata), .data_sram_rvalid(rvalid),
    .mem_to_wb_bus(mem_to_wb_bus), .hl_mem_to_wb(hl_mem_to_wb),
    .mem_to_id_bus(mem_to_id_bus), .mem_to_id_hl(mem_to_id_hl),
    .stallreq_mem(stallreq_mem)
  );

  always #5 clk = ~clk;

  function automatic logic [73:0] mk(input logic [31:0] pc, input logic ld,
                                     input logic [2:0] t, input logic we,
                                     input logic [4:0] wa, input logic [31:0] res);
    return {pc, ld, t, we, wa, res};
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] t,
                                      input logic [1:0] a);
    int          bi;
    int          hi;
    logic [7:0]  b;
    logic [15:0] h;
    bi = int'(a) * 8;
    hi = int'(a[1]) * 16;
    b  = w[bi +: 8];
    h  = w[hi +: 16];
    case (t)
      3'd0:    return 32'($signed(b));
      3'd1:    return {24'd0, b};
      3'd2:    return 32'($signed(h));
      3'd3:    return {16'd0, h};
      default: return w;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bus  = 74'd0;
    m_hl   = 66'd0;
    m_hold = 32'd0;
    m_mode = 0;
  endtask

  task automatic check_all();
    logic        ld, sr;
    logic [31:0] src, wd;
    ld  = m_bus[41];
    src = (m_mode == 2) ? m_hold : rdata;
    wd  = ld ? ext(src, m_bus[40:38], m_bus[1:0]) : m_bus[31:0];
    sr  = ld && !rvalid && (m_mode != 2);
    chk("wb_bus", mem_to_wb_bus, {m_bus[73:42], m_bus[37], m_bus[36:32], wd});
    chk("id_bus", 70'(mem_to_id_bus), 70'({m_bus[37] & ~sr, m_bus[36:32], wd}));
    chk("hl_wb", 70'(hl_mem_to_wb), 70'(m_hl));
    chk("id_hl", 70'(mem_to_id_hl), 70'(m_hl));
    chk("stallreq", 70'(stallreq_mem), 70'(sr));
  endtask

  task automatic model_step();
    logic bubble, ld;
    bubble = stall[3] && !stall[4];
    ld     = m_bus[41];
    if (m_mode == 0) begin
      if (ld && !rvalid) m_mode = 1;
      else if (ld && rvalid && stall[4]) begin m_mode = 2; m_hold = rdata; end
    end else if (m_mode == 1) begin
      if (bubble) m_mode = 0;
      else if (rvalid && stall[4]) begin m_mode = 2; m_hold = rdata; end
      else if (rvalid) m_mode = 0;
    end else begin
      if (bubble || !stall[4]) m_mode = 0;
    end
    if (bubble) begin
      m_bus = 74'd0;
      m_hl  = 66'd0;
    end else if (!stall[3]) begin
      m_bus = exb;
      m_hl  = hlin;
    end
  endtask

  task automatic tick();
    if (!resetn) model_reset();
    check_all();
    @(posedge clk);
    if (!resetn) model_reset();
    else model_step();
    #1;
  endtask

  initial begin
    resetn = 1'b0; stall = 6'd0; exb = 74'd0; hlin = 66'd0; rdata = 32'd0; rvalid = 1'b0;
    model_reset();
    #2;
    chk("rst_wb", mem_to_wb_bus, 70'd0);
    chk("rst_sr", 70'(stallreq_mem), 70'd0);
    tick(); tick();

    resetn = 1'b1;
    exb  = mk(32'h100, 1'b1, 3'b100, 1'b1, 5'd3, 32'h1000);
    hlin = 66'h3_1234_5678_9abc_def0;
    #2; chk("post_rst_wb", mem_to_wb_bus, 70'd0);
    chk("post_rst_hl", 70'(hl_mem_to_wb), 70'd0);
    tick();

    // lw with data on the first MEM cycle
    exb = mk(32'h104, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0); rvalid = 1'b1; rdata = 32'h8899AABB;
    #2; chk("lw_wdata", 70'(mem_to_wb_bus[31:0]), 70'(32'h8899AABB));
    chk("lw_sr", 70'(stallreq_mem), 70'd0);
    tick();

    // byte/halfword extraction
    exb = mk(32'h108, 1'b1, 3'b000, 1'b1, 5'd4, 32'h2003); rdata = 32'd0;
    #2; tick();
    exb = mk(32'h10c, 1'b1, 3'b001, 1'b1, 5'd5, 32'h2003); rdata = 32'h80112233;
    #2; chk("lb_11", 70'(mem_to_wb_bus[31:0]), 70'(32'hFFFFFF80)); tick();
    exb = mk(32'h110, 1'b1, 3'b010, 1'b1, 5'd6, 32'h2002);
    #2; chk("lbu_11", 70'(mem_to_wb_bus[31:0]), 70'(32'h00000080)); tick();
    exb = mk(32'h114, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0);
    #2; chk("lh_10", 70'(mem_to_wb_bus[31:0]), 70'(32'hFFFF8011)); tick();

    // lw waiting three cycles for data
    exb = mk(32'h200, 1'b1, 3'b100, 1'b1, 5'd7, 32'h3000); rvalid = 1'b0;
    #2; tick();
    exb = mk(32'h204, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      rvalid = 1'b0; stall = 6'b011111;
      #2; chk("wait_sr", 70'(stallreq_mem), 70'd1);
      chk("wait_fwd", 70'(mem_to_id_bus[37]), 70'd0);
      tick();
    end
    rvalid = 1'b1; rdata = 32'hCAFEF00D; stall = 6'd0;
    #2; chk("wait_done_sr", 70'(stallreq_mem), 70'd0);
    chk("wait_done_wd", 70'(mem_to_wb_bus[31:0]), 70'(32'hCAFEF00D));
    chk("wait_done_fwd", 70'(mem_to_id_bus[37]), 70'd1);
    tick();

    // data returned under downstream stall is held
    exb = mk(32'h300, 1'b1, 3'b100, 1'b1, 5'd9, 32'h4000); rvalid = 1'b0;
    #2; tick();
    exb = mk(32'h304, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0);
    rvalid = 1'b1; rdata = 32'h11112222; stall = 6'b011111;
    #2; chk("hold_entry", 70'(mem_to_wb_bus[31:0]), 70'(32'h11112222)); tick();
    rvalid = 1'b0; rdata = 32'hDEADBEEF;
    #2; chk("hold_1", 70'(mem_to_wb_bus[31:0]), 70'(32'h11112222));
    chk("hold_sr", 70'(stallreq_mem), 70'd0); tick();
    rvalid = 1'b1; rdata = 32'h55555555;
    #2; chk("hold_2", 70'(mem_to_wb_bus[31:0]), 70'(32'h11112222)); tick();
    stall = 6'd0; rdata = 32'd0; rvalid = 1'b0;
    #2; chk("hold_3", 70'(mem_to_wb_bus[31:0]), 70'(32'h11112222)); tick();

    // hold versus bubble
    exb  = mk(32'h400, 1'b0, 3'b000, 1'b1, 5'd10, 32'hABCD0123);
    hlin = 66'h2_0000_0001_0000_0002;
    #2; tick();
    exb = mk(32'h404, 1'b0, 3'b000, 1'b1, 5'd12, 32'd0); hlin = 66'd0; stall = 6'b011111;
    #2; tick();
    #2; chk("held_wb", mem_to_wb_bus, {32'h400, 1'b1, 5'd10, 32'hABCD0123});
    chk("held_hl", 70'(hl_mem_to_wb), 70'(66'h2_0000_0001_0000_0002));
    stall = 6'b001111;
    tick();
    stall = 6'd0; exb = 74'd0;
    #2; chk("bubble_wb", mem_to_wb_bus, 70'd0);
    chk("bubble_hl", 70'(hl_mem_to_wb), 70'd0);
    tick();

    // reset in the middle of a waiting load
    exb = mk(32'h500, 1'b1, 3'b100, 1'b1, 5'd11, 32'h5000); rvalid = 1'b0;
    #2; tick();
    exb = 74'd0; stall = 6'b011111;
    #2; chk("pre_rst_sr", 70'(stallreq_mem), 70'd1); tick();
    resetn = 1'b0;
    #2; chk("mid_rst_wb", mem_to_wb_bus, 70'd0);
    chk("mid_rst_sr", 70'(stallreq_mem), 70'd0);
    tick();
    resetn = 1'b1; rvalid = 1'b1; rdata = 32'h12345678; stall = 6'd0;
    for (int i = 0; i < 3; i++) begin
      #2; chk("after_rst_id", 70'(mem_to_id_bus), 70'd0);
      chk("after_rst_we", 70'(mem_to_wb_bus[37]), 70'd0);
      tick();
    end

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int sel;
      resetn = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      sel = int'($urandom_range(0, 5));
      case (sel)
        0, 1, 2: stall = 6'd0;
        3:       stall = 6'b011111;
        4:       stall = 6'b001111;
        default: stall = 6'($urandom);
      endcase
      exb    = mk($urandom, 1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom), $urandom);
      hlin   = {2'($urandom), $urandom, $urandom};
      rdata  = $urandom;
      rvalid = 1'($urandom);
      #2; tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
